data_mem_unit: RTL
==================

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter N, default 32: data width in bits; fixed at 32 (4 byte lanes).
REQ-002 Parameter ADDR_WIDTH, default 12: byte-address width; capacity 2^ADDR_WIDTH bytes.
REQ-003 Parameter WAIT_STATES, default 0: extra stall cycles per access, range 0..15.
REQ-004 Ports shall be:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  sign-extend load result.
- req_addr  input  N  byte address.
- req_wdata  input  N  store data, low-order bytes used.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  N  load result.
- resp_err  output  1  request rejected.

Function
REQ-005 Storage shall be byte-addressable, little-endian: the byte at addr occupies bits 7:0, addr+1 bits 15:8, and so on.
REQ-006 Storage shall be 4 byte lanes, each 2^(ADDR_WIDTH-2) entries; lane = addr[1:0], row = addr[ADDR_WIDTH-1:2].
REQ-007 A request shall be accepted on a rising edge where req_valid=1 and req_ready=1; all request fields are captured at that edge.
REQ-008 FSM states: IDLE, WAIT, ACC0, ACC1, RESP; req_ready=1 only in IDLE.
REQ-009 IDLE on accept: go to RESP if the request is erroneous; otherwise go to WAIT if WAIT_STATES>0, else ACC0.
REQ-010 WAIT shall count WAIT_STATES cycles, then go to ACC0.
REQ-011 ACC0 shall access the bytes within the first aligned row; go to ACC1 if the access crosses a row boundary, else RESP.
REQ-012 ACC1 shall access the remaining bytes in row+1, then go to RESP.
REQ-013 RESP shall assert resp_valid for exactly one cycle, then go to IDLE.
REQ-014 Latency from the accept edge to resp_valid high: 2+WAIT_STATES cycles for non-crossing accesses; 3+WAIT_STATES for crossing accesses; 1 for erroneous requests.
REQ-015 A request is erroneous if:
- req_size=11, or
- any of req_addr[N-1:ADDR_WIDTH] is nonzero, or
- addr + bytes - 1 exceeds 2^ADDR_WIDTH - 1 (no wrap-around).
REQ-016 An erroneous request shall perform no storage write and respond with resp_err=1 and resp_rdata=0.
REQ-017 Store: write exactly 1/2/4 bytes, taken from req_wdata[7:0]/[15:0]/[31:0]; other bytes are unchanged.
REQ-018 Store resp_rdata shall be 0.
REQ-019 Write commit is per beat: bytes are written at the end of the ACC0 or ACC1 cycle that covers them.
REQ-020 Load result: bytes right-justified in resp_rdata; upper bits zero if req_signed=0, copies of the MSB of the loaded value if req_signed=1; req_signed is ignored for word loads.
REQ-021 resp_rdata and resp_err shall be valid only while resp_valid=1 and hold their value until the next response.
REQ-022 req_valid asserted outside IDLE shall be ignored (not queued).

Reset
REQ-023 rst_n=0 shall immediately force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, and clear the wait counter.
REQ-024 Storage contents shall not be reset and are undefined until written.
REQ-025 Reset asserted mid-access shall abort the access with no response; bytes already committed in ACC0 stay written; ACC1 bytes are not written.
REQ-026 The first accept after rst_n deasserts shall be possible on the first rising edge with rst_n=1.

Verification
REQ-027 Word store 0xDEADBEEF to 0x010, then word load 0x010 -> rdata 0xDEADBEEF, err 0, resp_valid exactly 2 cycles after accept (WAIT_STATES=0).
REQ-028 After REQ-027, byte load 0x011 signed -> 0xFFFFFFBE; unsigned -> 0x000000BE; halfword load 0x012 signed -> 0xFFFFDEAD.
REQ-029 Word store 0x11223344 to 0x00E (row crossing), then word load 0x00E -> 0x11223344, latency 3; byte load 0x00D -> previous contents unchanged.
REQ-030 Word load 0xFFE with ADDR_WIDTH=12 -> err 1, rdata 0, latency 1; also size=11 -> err 1; also addr 0x1000 -> err 1, no storage changed.
REQ-031 WAIT_STATES=3, aligned load -> resp_valid at 5 cycles; req_ready=0 throughout the access; req_valid pulses mid-access produce no extra response.
REQ-032 Crossing store to 0x00E; rst_n low during the ACC1 cycle -> no resp_valid, req_ready=1 immediately; bytes 0x00E-0x00F hold new data, 0x010-0x011 hold old data.

Source files
------------

// File: rtl/data_mem_unit.sv
// Byte-addressable little-endian data memory with 4 byte lanes, misaligned
// row-crossing accesses split into two beats, and optional wait states.
module data_mem_unit #(
  parameter int N           = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err
);

  localparam int RW   = ADDR_WIDTH - 2;
  localparam int ROWS = 1 << RW;
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [2:0] {IDLE, WAIT, ACC0, ACC1, RESP} state_t;

  state_t                r_state, w_state_next;
  logic                  r_write, r_signed, r_err;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [N-1:0]          r_wdata, r_buf, r_rdata;
  logic [3:0]            r_wait_cnt;
  logic [7:0]            r_mem [4][ROWS];

  logic [2:0]            w_req_nb, w_nb, w_off_end;
  logic [ADDR_WIDTH:0]   w_req_end;
  logic                  w_req_err, w_cross;
  logic [RW-1:0]         w_row;
  logic [3:0]            w_lane_en;
  logic [1:0]            w_lane_k [4];
  logic [N-1:0]          w_buf, w_load;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign w_req_nb  = size_bytes(req_size);
  assign w_req_end = {1'b0, req_addr[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(w_req_nb - 3'd1);
  assign w_req_err = (req_size == 2'b11) || (|req_addr[N-1:ADDR_WIDTH]) || w_req_end[ADDR_WIDTH];

  assign w_nb      = size_bytes(r_size);
  assign w_off_end = {1'b0, r_addr[1:0]} + w_nb - 3'd1;
  assign w_cross   = w_off_end[2];

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (req_valid) begin
        if (w_req_err)             w_state_next = RESP;
        else if (WAIT_STATES > 0)  w_state_next = WAIT;
        else                       w_state_next = ACC0;
      end
      WAIT:    if (r_wait_cnt == WAIT_LAST) w_state_next = ACC0;
      ACC0:    w_state_next = w_cross ? ACC1 : RESP;
      ACC1:    w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Lane l carries access byte k = l - addr[1:0]; beat 0 owns lanes at or above the start lane.
  always_comb begin
    w_row     = r_addr[ADDR_WIDTH-1:2] + RW'(r_state == ACC1);
    w_buf     = r_buf;
    w_lane_en = '0;
    for (int l = 0; l < 4; l++) begin
      w_lane_k[l]  = 2'(l) - r_addr[1:0];
      w_lane_en[l] = ({1'b0, w_lane_k[l]} < w_nb) &&
                     (((r_state == ACC0) && (2'(l) >= r_addr[1:0])) ||
                      ((r_state == ACC1) && (2'(l) <  r_addr[1:0])));
      if (w_lane_en[l]) w_buf[8*w_lane_k[l] +: 8] = r_mem[l][w_row];
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   w_load = r_signed ? {{24{w_buf[7]}},  w_buf[7:0]}  : {24'b0, w_buf[7:0]};
      2'b01:   w_load = r_signed ? {{16{w_buf[15]}}, w_buf[15:0]} : {16'b0, w_buf[15:0]};
      default: w_load = w_buf;
    endcase
  end

  // NOTE: storage has no reset; an aborted ACC1 beat never writes because reset has already forced IDLE.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (r_write && w_lane_en[l]) r_mem[l][w_row] <= r_wdata[8*w_lane_k[l] +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_write    <= req_write;
          r_size     <= req_size;
          r_signed   <= req_signed;
          r_addr     <= req_addr[ADDR_WIDTH-1:0];
          r_wdata    <= req_wdata;
          r_buf      <= '0;
          r_wait_cnt <= '0;
          if (w_req_err) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        WAIT: r_wait_cnt <= r_wait_cnt + 4'd1;
        ACC0, ACC1: begin
          r_buf <= w_buf;
          if (w_state_next == RESP) begin
            r_err   <= 1'b0;
            r_rdata <= r_write ? '0 : w_load;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
